// File: rtl/gpr.sv
// General-purpose bus register: captures data_in when wa is high, drives data_out while oa is high.
// Define GPR_TRISTATE_EN to float data_out (all Z) when oa=0; the default build drives zeros instead.
module gpr #(
  parameter int                 WIDTH       = 8,
  parameter logic [0:WIDTH-1]   RESET_VALUE = {WIDTH{1'b0}}
) (
  output wire  [0:WIDTH-1] data_out,
  input  logic [0:WIDTH-1] data_in,
  input  logic             clk,
  input  logic             clr,
  input  logic             wa,
  input  logic             oa
);

  logic [0:WIDTH-1] store;
  logic [0:WIDTH-1] store_d;

  // Next-state selection: load the bus on write-enable, otherwise hold.
  always_comb begin
    store_d = store;
    if (wa) begin
      store_d = data_in;
    end else begin
      store_d = store;
    end
  end

  // Storage flop; clr is asynchronous and overrides any write.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      store <= RESET_VALUE;
    end else begin
      store <= store_d;
    end
  end

`ifdef GPR_TRISTATE_EN
  assign data_out = oa ? store : {WIDTH{1'bz}};
`else
  // Zero when idle so several registers can be OR-combined onto one bus.
  assign data_out = oa ? store : {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_gpr.sv
// Directed self-checking bench for gpr: reset, write, read, write/read overlap and output gating.
module tb_gpr;

  logic       clk;
  logic       clr;
  logic       wa;
  logic       oa;
  logic [0:7] data_in;
  wire  [0:7] data_out;

  int total;
  int bad;

  logic [0:7] off_val;
  logic [0:7] xval;

  gpr #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .data_out (data_out),
    .data_in  (data_in),
    .clk      (clk),
    .clr      (clr),
    .wa       (wa),
    .oa       (oa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    clr = 1'b1; wa = 1'b0; oa = 1'b0; data_in = 8'h00;
    #2 clr = 1'b0;
    #1;
    total++;
    if (dut.store !== 8'h00) begin
      bad++; $display("FAIL reset_async store got=%h want=%h", dut.store, 8'h00);
    end
    total++;
    if (data_out !== off_val) begin
      bad++; $display("FAIL reset_dout got=%h want=%h", data_out, off_val);
    end
    wa = 1'b1; data_in = 8'hFF;
    @(posedge clk); #1;
    total++;
    if (dut.store !== 8'h00) begin
      bad++; $display("FAIL reset_overrides_wa store got=%h want=%h", dut.store, 8'h00);
    end
    @(negedge clk);
    wa = 1'b0;
    clr = 1'b1;
  endtask

  task automatic test_write();
    @(negedge clk);
    data_in = 8'h55; wa = 1'b1;
    #1;
    total++;
    if (dut.store !== 8'h00) begin
      bad++; $display("FAIL write_before_edge store got=%h want=%h", dut.store, 8'h00);
    end
    @(posedge clk); #1;
    total++;
    if (dut.store !== 8'h55) begin
      bad++; $display("FAIL write_after_edge store got=%h want=%h", dut.store, 8'h55);
    end
    total++;
    if (data_out !== off_val) begin
      bad++; $display("FAIL write_dout_disabled got=%h want=%h", data_out, off_val);
    end
    @(negedge clk);
    wa = 1'b0; data_in = 8'h11;
    @(posedge clk); #1;
    total++;
    if (dut.store !== 8'h55) begin
      bad++; $display("FAIL write_hold store got=%h want=%h", dut.store, 8'h55);
    end
  endtask

  task automatic test_read_hold();
    @(negedge clk);
    oa = 1'b1; data_in = 8'hAA;
    #1;
    total++;
    if (data_out !== 8'h55) begin
      bad++; $display("FAIL read_immediate dout got=%h want=%h", data_out, 8'h55);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (dut.store !== 8'h55 || data_out !== 8'h55) begin
        bad++; $display("FAIL read_hold[%0d] store=%h dout=%h want=%h", i, dut.store, data_out, 8'h55);
      end
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    wa = 1'b1; oa = 1'b1; data_in = 8'hC3;
    #1;
    total++;
    if (data_out !== 8'h55) begin
      bad++; $display("FAIL wr_rd_before_edge dout got=%h want=%h", data_out, 8'h55);
    end
    @(posedge clk); #1;
    total++;
    if (data_out !== 8'hC3 || dut.store !== 8'hC3) begin
      bad++; $display("FAIL wr_rd_after_edge dout=%h store=%h want=%h", data_out, dut.store, 8'hC3);
    end
    @(negedge clk);
    wa = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [0:7] vals [3];
    vals[0] = 8'h3C; vals[1] = 8'h81; vals[2] = 8'h7E;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wa = 1'b1; data_in = vals[i];
      @(posedge clk); #1;
      total++;
      if (dut.store !== vals[i]) begin
        bad++; $display("FAIL b2b[%0d] store got=%h want=%h", i, dut.store, vals[i]);
      end
      if (i == 1) begin
        total++;
        if (dut.store[0] !== 1'b1 || dut.store[7] !== 1'b1 || dut.store[1] !== 1'b0) begin
          bad++; $display("FAIL msb_order store=%b want=10000001", dut.store);
        end
      end
    end
    @(negedge clk);
    wa = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    wa = 1'b1; oa = 1'b1; data_in = 8'hFF;
    #2 clr = 1'b0;
    #1;
    total++;
    if (dut.store !== 8'h00 || data_out !== 8'h00) begin
      bad++; $display("FAIL clr_mid_write store=%h dout=%h want=%h", dut.store, data_out, 8'h00);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if (dut.store !== 8'h00) begin
        bad++; $display("FAIL clr_held[%0d] store got=%h want=%h", i, dut.store, 8'h00);
      end
    end
    @(negedge clk);
    wa = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    total++;
    if (dut.store !== 8'h00) begin
      bad++; $display("FAIL clr_release store got=%h want=%h", dut.store, 8'h00);
    end
  endtask

  task automatic test_oa_off();
    @(negedge clk);
    wa = 1'b1; oa = 1'b1; data_in = 8'h9A;
    @(posedge clk); #1;
    total++;
    if (data_out !== 8'h9A) begin
      bad++; $display("FAIL oa_on dout got=%h want=%h", data_out, 8'h9A);
    end
    @(negedge clk);
    wa = 1'b0;
    #2 oa = 1'b0;
    #1;
    total++;
    if (data_out !== off_val) begin
      bad++; $display("FAIL oa_off dout got=%h want=%h", data_out, off_val);
    end
    total++;
    if (dut.store !== 8'h9A) begin
      bad++; $display("FAIL oa_off_store got=%h want=%h", dut.store, 8'h9A);
    end
  endtask

  task automatic test_x_capture();
    xval = 8'bxxxx_0101;
    @(negedge clk);
    wa = 1'b1; data_in = xval;
    @(posedge clk); #1;
    total++;
    if (dut.store !== xval) begin
      bad++; $display("FAIL x_capture store got=%b want=%b", dut.store, xval);
    end
    @(negedge clk);
    wa = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
`ifdef GPR_TRISTATE_EN
    off_val = 8'hzz;
`else
    off_val = 8'h00;
`endif
    test_reset();
    test_write();
    test_read_hold();
    test_write_read();
    test_back_to_back();
    test_reset_mid_write();
    test_oa_off();
    test_x_capture();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
